// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default widths for the multi-port register file
package regfile_pkg;
    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with range check, zero register and write bypass
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_mem [NUM_REGS],
    input  logic              i_wr_ok,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_err
);
    logic              w_oob, w_zero, w_byp;
    logic [DATA_W-1:0] w_data, r_data;
    logic              r_valid;

    assign w_oob   = 32'(i_addr) >= 32'(NUM_REGS);
    assign w_zero  = (ZERO_REG != 0) && (i_addr == '0);
    // i_wr_ok already excludes the zero register and the clear sweep
    assign w_byp   = (BYPASS != 0) && i_wr_ok && (i_wr_addr == i_addr);
    assign w_data  = (w_oob || i_clear || w_zero) ? '0 : w_byp ? i_wr_data : i_mem[i_addr];
    assign o_err   = i_en && w_oob;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) r_data <= w_data;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with bypass, zero register and clear sweep
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     addr_err
);
    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nx;
    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic              w_clear, w_last, w_wr_oob, w_wr_ok, r_addr_err;
    logic [NUM_RD-1:0] w_rd_err;

    assign w_clear  = r_state == ST_CLEAR;
    assign w_last   = r_ptr == ADDR_W'(NUM_REGS - 1);
    assign w_wr_oob = wr_en && (32'(wr_addr) >= 32'(NUM_REGS));
    assign w_wr_ok  = !w_clear && wr_en && !w_wr_oob && !((ZERO_REG != 0) && (wr_addr == '0));
    assign busy     = w_clear;
    assign addr_err = r_addr_err;

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = '0;
        if (w_clear) begin
            w_state_nx = w_last ? ST_READY : ST_CLEAR;
            w_ptr_nx   = w_last ? '0 : r_ptr + 1'b1;
        end else if (clr_req) begin
            w_state_nx = ST_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_ptr      <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_addr_err <= w_wr_oob || (|w_rd_err);
        end
    end

    // The array itself has no reset; the sweep zeroes it one entry per cycle
    always_ff @(posedge clk) begin
        if (w_clear) r_mem[r_ptr] <= '0;
        else if (w_wr_ok) r_mem[wr_addr] <= wr_data;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (rd_en[k]),
            .i_addr   (rd_addr[k*ADDR_W +: ADDR_W]),
            .i_clear  (w_clear),
            .i_mem    (r_mem),
            .i_wr_ok  (w_wr_ok),
            .i_wr_addr(wr_addr),
            .i_wr_data(wr_data),
            .o_data   (rd_data[k*DATA_W +: DATA_W]),
            .o_valid  (rd_valid[k]),
            .o_err    (w_rd_err[k])
        );
    end
endmodule
